// File: rtl/leds_uart_reporter.sv
// Watches the SOC LEDS register and prints each new value over UART 8N1
// as eight uppercase hex digits followed by CR LF.
module leds_uart_reporter #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] LEDS,
    output logic        TX,
    output logic        BUSY,
    output logic        DROPPED
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [3:0]    byte_idx;
    logic [31:0]   prev_leds;
    logic [31:0]   shadow;
    logic [31:0]   pending;
    logic          pending_valid;

    logic          change;
    logic [31:0]   shifted;
    logic [3:0]    nib;
    logic [7:0]    cur_byte;
    logic [2:0]    nxt_bit;

    assign change = (LEDS != prev_leds);

    // Character for the current byte slot, built from the frozen shadow value
    always_comb begin
        shifted  = shadow << {byte_idx[2:0], 2'b00};
        nib      = shifted[31:28];
        nxt_bit  = bit_idx + 3'd1;
        cur_byte = 8'h00;
        if (byte_idx == 4'd8) begin
            cur_byte = 8'h0D;
        end else if (byte_idx == 4'd9) begin
            cur_byte = 8'h0A;
        end else if (nib < 4'd10) begin
            cur_byte = {4'h3, nib};
        end else begin
            cur_byte = 8'h37 + {4'h0, nib};
        end
    end

    // Change tracking, overrun bookkeeping and the serialiser FSM
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            byte_idx      <= '0;
            prev_leds     <= '0;
            shadow        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            TX            <= 1'b1;
            BUSY          <= 1'b0;
            DROPPED       <= 1'b0;
        end else begin
            prev_leds <= LEDS;
            if (state != IDLE && change) begin
                pending       <= LEDS;
                pending_valid <= 1'b1;
                if (pending_valid) begin
                    DROPPED <= 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    TX <= 1'b1;
                    if (change) begin
                        shadow   <= LEDS;
                        byte_idx <= '0;
                        cnt      <= '0;
                        state    <= START;
                        TX       <= 1'b0;
                        BUSY     <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        TX      <= cur_byte[0];
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            TX    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= nxt_bit;
                            TX      <= cur_byte[nxt_bit];
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        TX  <= 1'b0;
                        if (byte_idx != 4'd9) begin
                            byte_idx <= byte_idx + 4'd1;
                            state    <= START;
                        end else begin
                            byte_idx <= '0;
                            if (change) begin
                                // Newest value wins over a queued one
                                shadow        <= LEDS;
                                pending_valid <= 1'b0;
                                if (pending_valid) begin
                                    DROPPED <= 1'b1;
                                end
                                state <= START;
                            end else if (pending_valid) begin
                                shadow        <= pending;
                                pending_valid <= 1'b0;
                                state         <= START;
                            end else begin
                                state <= IDLE;
                                BUSY  <= 1'b0;
                                TX    <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/leds_uart_reporter.md
Name: leds_uart_reporter

Overview:
- Downstream consumer of the SOC's 32-bit LEDS output.
- Detects every change on LEDS and serialises the new value as a UART 8N1 text line: 8 uppercase hex digits, then CR, then LF.
- Gives a physical-pin equivalent of the bench's change-triggered LEDS display.
- Runs on the same divided clock as the SOC.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit; legal values ≥2; counter width is $clog2(CLKS_PER_BIT).

Ports:
- CLK  input  1  system clock (divided clock that also drives the SOC).
- RESET  input  1  asynchronous, active-low reset.
- LEDS  input  32  SOC LED register, sampled every rising edge.
- TX  output  1  UART serial line, idle high, registered.
- BUSY  output  1  high while a line is being transmitted.
- DROPPED  output  1  sticky flag: at least one LEDS value was never reported.

Behaviour:
- Reset (RESET=0, asynchronous, overrides everything):
  - TX=1, BUSY=0, DROPPED=0.
  - prev_LEDS=0, pending_valid=0, state=IDLE, all counters 0.
  - Assertion mid-frame aborts the frame; TX returns high immediately, with no clock edge needed.
- Change detection:
  - prev_LEDS <= LEDS on every edge.
  - change = (LEDS != prev_LEDS), evaluated at the edge.
  - After reset release with LEDS≠0, the first edge counts as a change.
- Line format: 10 bytes per line.
  - Bytes 0..7: hex digits of the captured value, most significant nibble first.
  - Nibble 0-9 maps to 0x30+n; nibble 10-15 maps to 0x41+(n-10).
  - Byte 8 = 0x0D, byte 9 = 0x0A.
- Byte format:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Line duration = 100*CLKS_PER_BIT cycles.
  - No idle gap between the bytes of a line.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TX=1, BUSY=0. On change: shadow <= LEDS, byte_idx=0, go to START. TX goes 0 and BUSY goes 1 on that same edge.
  - START: TX=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: TX = byte[bit_idx], each bit for CLKS_PER_BIT cycles; after bit 7, go to STOP.
  - STOP: TX=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - If byte_idx<9: byte_idx+1, go to START.
    - Otherwise the line is complete; see next-line selection.
- Changes while busy (state≠IDLE):
  - On each change: pending <= LEDS.
  - If pending_valid was already 1, DROPPED <= 1.
  - pending_valid <= 1.
- Next-line selection, on the final edge of the last STOP bit:
  - If change on this edge: shadow <= LEDS, go to START. If pending_valid is also 1, DROPPED <= 1 (the newer value wins). Clear pending_valid.
  - Else if pending_valid: shadow <= pending, clear pending_valid, go to START.
  - Else: go to IDLE, BUSY <= 0.
  - A back-to-back line starts with TX=0 on that edge; no idle-high cycle is inserted.
- DROPPED clears only on reset.
- The shadow register is stable for the whole line. Hex digits are derived from shadow and byte_idx, never from live LEDS.

Test Plan:
- Idle: reset, then LEDS=0 held for 1000 cycles → TX=1, BUSY=0, DROPPED=0 throughout.
- Single line: CLKS_PER_BIT=4, LEDS 0→0x000000A5 → TX decodes 30 30 30 30 30 30 41 35 0D 0A. BUSY is high for exactly 400 cycles, and TX falls on the edge that detects the change.
- One change mid-line: 0xDEADBEEF, then 0x12345678 during byte 3 → two consecutive lines "DEADBEEF\r\n" and "12345678\r\n" with no idle gap; DROPPED=0.
- Overrun: during a line, LEDS changes to 0x1 and then to 0x2 → second line is "00000002\r\n"; DROPPED=1 and stays 1 afterwards.
- Final-edge collision:
  - Case A: LEDS changes exactly on the last STOP edge with no pending value → next line starts on that edge with the new value.
  - Case B: same, but pending_valid=1 → the new value is sent and DROPPED=1.
- Reset mid-frame: drive RESET=0 during DATA of byte 4 → TX=1 and BUSY=0 with no clock edge. Release with LEDS=0x000000FF → line "000000FF\r\n" begins on the first edge.
